en_period_checker: RTL and testbench

//  Receive-side monitor for the periodic enable strobe that paces symbol processing.

---
 rtl/en_period_checker.sv | 201 ++++++++++++++++++++
 tb/tb_en_period_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/en_period_checker.sv
`default_nettype none
//=============================================================================
// Module      : en_period_checker
// Description : Receive-side monitor for the periodic enable strobe that
//               paces symbol processing. Measures the cycle distance between
//               strobes, compares it with the expected period INTERVAL+1
//               (+/- TOL), declares lock after LOCK_COUNT consecutive good
//               periods and then forwards qualified strobes downstream.
//               Late, early and missing strobes while locked raise err_pulse.
// Optional    : ERR_COUNT_EN - when defined, err_count is a saturating
//               16-bit loss-of-lock counter (cleared only by rst); when
//               undefined, err_count is tied to zero.
// Ports       : clk       - system clock
//               rst       - asynchronous reset, active high
//               check_en  - level enable for monitoring; low forces IDLE
//               en_in     - incoming one-cycle strobe
//               en_out    - registered qualified strobe (only while locked)
//               locked    - high while in the LOCKED state
//               err_pulse - one-cycle pulse on any loss of lock
//               period    - last measured strobe period, in cycles
//               err_count - saturating loss-of-lock count
// Revision    : 1.0 - initial release
//=============================================================================
module en_period_checker #(
    parameter int INTERVAL   = 10,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             check_en,
    input  logic             en_in,
    output logic             en_out,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] period,
    output logic [15:0]      err_count
);

    localparam int GOOD_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    // Upper edge of the acceptance window; also the cnt value at which a
    // missing strobe is declared.
    localparam logic [CNT_W-1:0]  c_hi         = CNT_W'(INTERVAL + 1 + TOL);
    localparam logic [GOOD_W-1:0] c_lock_last  = GOOD_W'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARM    = 2'd1,
        S_ACQ    = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [GOOD_W-1:0]   r_good_cnt;
    logic                r_en_out;
    logic                r_locked;
    logic                r_err_pulse;
    logic [CNT_W-1:0]    r_period;

    logic [CNT_W-1:0]    w_meas;
    logic                w_lo_ok;
    logic                w_good;
    logic                w_timeout;
    logic                w_fault;

    // Measured period of a strobe in this cycle; saturates with the counter
    // so a very long gap never wraps into the acceptance window.
    assign w_meas = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    // When TOL reaches P the lower bound collapses to zero and every
    // measurement passes the lower check.
    generate
        if (TOL >= INTERVAL + 1) begin : g_lo_open
            assign w_lo_ok = 1'b1;
        end else begin : g_lo_chk
            localparam logic [CNT_W-1:0] c_lo = CNT_W'(INTERVAL + 1 - TOL);
            assign w_lo_ok = (w_meas >= c_lo);
        end
    endgenerate

    assign w_good    = w_lo_ok && (w_meas <= c_hi);
    // A strobe arriving on the timeout cycle wins, hence the !en_in term.
    assign w_timeout = !en_in && (r_cnt == c_hi);
    // Loss of lock: bad strobe or missing strobe while locked and enabled.
    assign w_fault   = check_en && (r_state == S_LOCKED) &&
                       ((en_in && !w_good) || w_timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_good_cnt  <= '0;
            r_en_out    <= 1'b0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_period    <= '0;
        end else begin
            r_en_out    <= 1'b0;
            r_err_pulse <= w_fault;
            if (!check_en) begin
                // period is deliberately held across a disable.
                r_state    <= S_IDLE;
                r_cnt      <= '0;
                r_good_cnt <= '0;
                r_locked   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt      <= '0;
                        r_good_cnt <= '0;
                        r_state    <= S_ARM;
                    end
                    S_ARM: begin
                        if (en_in) begin
                            // First strobe only opens the measurement window.
                            r_period   <= w_meas;
                            r_cnt      <= '0;
                            r_good_cnt <= '0;
                            r_state    <= S_ACQ;
                        end else begin
                            r_cnt <= w_meas;
                        end
                    end
                    S_ACQ: begin
                        if (en_in) begin
                            r_period <= w_meas;
                            r_cnt    <= '0;
                            if (w_good) begin
                                r_good_cnt <= r_good_cnt + GOOD_W'(1);
                                if (r_good_cnt == c_lock_last) begin
                                    // The lock-completing strobe is forwarded.
                                    r_state  <= S_LOCKED;
                                    r_locked <= 1'b1;
                                    r_en_out <= 1'b1;
                                end
                            end else begin
                                r_good_cnt <= '0;
                            end
                        end else begin
                            r_cnt <= w_meas;
                            if (w_timeout) begin
                                r_good_cnt <= '0;
                                r_state    <= S_ARM;
                            end
                        end
                    end
                    S_LOCKED: begin
                        if (en_in) begin
                            r_period <= w_meas;
                            r_cnt    <= '0;
                            if (w_good) begin
                                r_en_out <= 1'b1;
                            end else begin
                                r_good_cnt <= '0;
                                r_locked   <= 1'b0;
                                r_state    <= S_ACQ;
                            end
                        end else begin
                            r_cnt <= w_meas;
                            if (w_timeout) begin
                                r_good_cnt <= '0;
                                r_locked   <= 1'b0;
                                r_state    <= S_ARM;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ERR_COUNT_EN
    logic [15:0] r_err_count;

    // Counts alongside err_pulse; survives check_en=0, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
        end else if (w_fault && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

    assign en_out    = r_en_out;
    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign period    = r_period;

endmodule
`default_nettype wire

// File: tb/tb_en_period_checker.sv
`default_nettype none
//=============================================================================
// Module      : tb_en_period_checker
// Description : Self-checking bench for en_period_checker (INTERVAL=10,
//               TOL=1, LOCK_COUNT=4, so P=11). Directed lock / fault /
//               timeout / disable / reset steps followed by randomized strobe
//               gaps, every cycle compared with a behavioural model that
//               tracks the elapsed time since the last strobe.
// Revision    : 1.0 - initial release
//=============================================================================
module tb_en_period_checker;

    localparam int INTERVAL   = 10;
    localparam int TOL        = 1;
    localparam int LOCK_COUNT = 4;
    localparam int CNT_W      = 32;
    localparam int PER        = INTERVAL + 1;
    localparam int LO         = (TOL > PER) ? 0 : PER - TOL;
    localparam int HI         = PER + TOL;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             check_en = 1'b0;
    logic             en_in = 1'b0;
    logic             en_out;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] period;
    logic [15:0]      err_count;

    int n_vec = 0;
    int n_err = 0;

    // Model: monitoring phase and elapsed time since the last strobe.
    typedef enum int {P_IDLE, P_WAIT_FIRST, P_ACQUIRE, P_LOCK} phase_t;
    phase_t m_phase;
    int     m_since;
    int     m_good_run;
    int     m_period;
    int     m_losses;
    bit     m_en_out;
    bit     m_locked;
    bit     m_err;

    en_period_checker #(
        .INTERVAL  (INTERVAL),
        .TOL       (TOL),
        .LOCK_COUNT(LOCK_COUNT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .check_en (check_en),
        .en_in    (en_in),
        .en_out   (en_out),
        .locked   (locked),
        .err_pulse(err_pulse),
        .period   (period),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CNT_W-1:0] obs,
                       input logic [CNT_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_err_count();
`ifdef ERR_COUNT_EN
        return (m_losses > 65535) ? 65535 : m_losses;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_phase    = P_IDLE;
        m_since    = 0;
        m_good_run = 0;
        m_period   = 0;
        m_losses   = 0;
        m_en_out   = 0;
        m_locked   = 0;
        m_err      = 0;
    endtask

    task automatic lose_lock(input phase_t next);
        m_err    = 1;
        m_losses = m_losses + 1;
        m_locked = 0;
        m_good_run = 0;
        m_phase  = next;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_step(input bit en, input bit ce);
        int  meas;
        bit  in_window;
        bit  missing;
        m_en_out  = 0;
        m_err     = 0;
        meas      = m_since + 1;
        in_window = (meas >= LO) && (meas <= HI);
        missing   = !en && (m_since == HI);
        if (!ce) begin
            m_phase    = P_IDLE;
            m_since    = 0;
            m_good_run = 0;
            m_locked   = 0;
            return;
        end
        if (m_phase == P_IDLE) begin
            m_since    = 0;
            m_good_run = 0;
            m_phase    = P_WAIT_FIRST;
            return;
        end
        if (en) begin
            m_period = meas;
            m_since  = 0;
            if (m_phase == P_WAIT_FIRST) begin
                m_good_run = 0;
                m_phase    = P_ACQUIRE;
            end else if (m_phase == P_ACQUIRE) begin
                m_good_run = in_window ? m_good_run + 1 : 0;
                if (m_good_run >= LOCK_COUNT) begin
                    m_phase  = P_LOCK;
                    m_locked = 1;
                    m_en_out = 1;
                end
            end else begin
                if (in_window) m_en_out = 1;
                else           lose_lock(P_ACQUIRE);
            end
        end else begin
            m_since = m_since + 1;
            if (missing && m_phase == P_ACQUIRE) begin
                m_good_run = 0;
                m_phase    = P_WAIT_FIRST;
            end else if (missing && m_phase == P_LOCK) begin
                lose_lock(P_WAIT_FIRST);
            end
        end
    endtask

    task automatic check_all();
        chk("en_out",    CNT_W'(en_out),    CNT_W'(m_en_out));
        chk("locked",    CNT_W'(locked),    CNT_W'(m_locked));
        chk("err_pulse", CNT_W'(err_pulse), CNT_W'(m_err));
        chk("period",    period,            CNT_W'(m_period));
        chk("err_count", CNT_W'(err_count), CNT_W'(exp_err_count()));
    endtask

    task automatic tick(input bit en, input bit ce);
        check_en = ce;
        en_in    = en;
        @(posedge clk);
        model_step(en, ce);
        #1;
        check_all();
    endtask

    // Strobe arriving g cycles after the previous one.
    task automatic gap(input int g);
        repeat (g - 1) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
    endtask

    initial begin
        int r;
        int exp_losses;
        model_reset();
        #12;
        check_all();
        rst = 1'b0;

        // Enable and lock on the 5th strobe of an 11-cycle train.
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        repeat (5) gap(11);
        chk("lock_on_5th", CNT_W'(locked), CNT_W'(1));
        chk("en_out_5th",  CNT_W'(en_out), CNT_W'(1));
        chk("period_11",   period, CNT_W'(11));

        // Edges of the tolerance window keep lock.
        gap(10);
        chk("period_10", period, CNT_W'(10));
        gap(12);
        chk("period_12", period, CNT_W'(12));
        chk("still_locked", CNT_W'(locked), CNT_W'(1));

        // Late strobe drops lock, then relock in 4 good periods.
        gap(13);
        chk("late_err", CNT_W'(err_pulse), CNT_W'(1));
        chk("late_unlock", CNT_W'(locked), CNT_W'(0));
        chk("period_13", period, CNT_W'(13));
        repeat (4) gap(11);
        chk("relock", CNT_W'(locked), CNT_W'(1));

        // Missing strobes: timeout, then one arming strobe plus 4 to relock.
        repeat (20) tick(1'b0, 1'b1);
        chk("timeout_unlock", CNT_W'(locked), CNT_W'(0));
        gap(11);
        chk("arm_no_lock", CNT_W'(locked), CNT_W'(0));
        repeat (4) gap(11);
        chk("relock_after_to", CNT_W'(locked), CNT_W'(1));

        // One-cycle disable clears lock without an error.
        tick(1'b0, 1'b0);
        chk("dis_unlock", CNT_W'(locked), CNT_W'(0));
        chk("dis_no_err", CNT_W'(err_pulse), CNT_W'(0));
        repeat (5) gap(11);
        chk("relock_after_dis", CNT_W'(locked), CNT_W'(1));

        // Early strobe: third loss of lock.
        gap(9);
        chk("early_err", CNT_W'(err_pulse), CNT_W'(1));
`ifdef ERR_COUNT_EN
        exp_losses = 3;
`else
        exp_losses = 0;
`endif
        chk("err_count_3", CNT_W'(err_count), CNT_W'(exp_losses));

        // Randomized strobe gaps, timeouts and disables.
        repeat (300) begin
            r = $urandom_range(0, 19);
            if (r <= 11)       gap(11);
            else if (r <= 13)  gap(10);
            else if (r <= 15)  gap(12);
            else if (r == 16)  gap(13);
            else if (r == 17)  gap(9);
            else if (r == 18)  gap($urandom_range(14, 20));
            else               repeat ($urandom_range(1, 2)) tick(1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of acquisition.
        tick(1'b0, 1'b0);
        gap(11);
        gap(11);
        repeat (3) tick(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_en_out",    CNT_W'(en_out),    CNT_W'(0));
        chk("rst_locked",    CNT_W'(locked),    CNT_W'(0));
        chk("rst_err_pulse", CNT_W'(err_pulse), CNT_W'(0));
        chk("rst_period",    period,            CNT_W'(0));
        chk("rst_err_count", CNT_W'(err_count), CNT_W'(0));
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        tick(1'b0, 1'b1);
        repeat (5) gap(11);
        chk("lock_after_rst", CNT_W'(locked), CNT_W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
